// File: rtl/multi_acc_core.sv
// Multi-channel streaming accumulator: per-channel running sums of a programmable
// length, with optional saturation and a single-entry valid/ready result register.
module multi_acc_core #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned DWIDTH        = 16,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IN_DATA_WIDTH-1:0] number_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic                     valid_i,
  input  logic                     run_i,
  input  logic [CNT_WIDTH-1:0]     len_i,
  input  logic                     sat_en_i,
  input  logic                     ready_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [CH_W-1:0]          ch_o,
  output logic [DWIDTH-1:0]        result_o,
  output logic                     ovf_o
);

  localparam int unsigned SW = DWIDTH + 1;

  typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

  logic [DWIDTH-1:0]    acc_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q;

  out_state_e        state_q;
  logic [DWIDTH-1:0] res_q;
  logic [CH_W-1:0]   ch_q;
  logic              ovf_out_q;

  logic [DWIDTH-1:0]    acc_sel;
  logic [CNT_WIDTH-1:0] cnt_sel;
  logic                 ovf_sel;
  logic                 ch_ok;
  logic                 accept;
  logic [SW-1:0]        sum_w;
  logic                 carry;
  logic [DWIDTH-1:0]    sum_n;
  logic [CNT_WIDTH:0]   len_eff;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic                 done;

  assign valid_o  = (state_q == StFull);
  assign ready_o  = !valid_o || ready_i;
  assign result_o = res_q;
  assign ch_o     = ch_q;
  assign ovf_o    = ovf_out_q;

  always_comb begin
    acc_sel = '0;
    cnt_sel = '0;
    ovf_sel = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_i == CH_W'(c)) begin
        acc_sel = acc_q[c];
        cnt_sel = cnt_q[c];
        ovf_sel = ovf_q[c];
      end
    end
  end

  always_comb begin
    ch_ok   = 32'(ch_i) < NUM_CH;
    accept  = valid_i && run_i && ready_o && ch_ok;
    sum_w   = {1'b0, acc_sel} + SW'(number_i);
    carry   = sum_w[DWIDTH];
    sum_n   = (carry && sat_en_i) ? '1 : sum_w[DWIDTH-1:0];
    // A zero length behaves as a single-sample accumulation.
    len_eff = (len_i == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, len_i};
    cnt_inc = {1'b0, cnt_sel} + (CNT_WIDTH+1)'(1);
    done    = accept && (cnt_inc >= len_eff);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      ovf_q <= '0;
    end else if (!run_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      ovf_q <= '0;
    end else if (accept) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_i == CH_W'(c)) begin
          if (done) begin
            acc_q[c] <= '0;
            cnt_q[c] <= '0;
            ovf_q[c] <= 1'b0;
          end else begin
            acc_q[c] <= sum_n;
            cnt_q[c] <= cnt_inc[CNT_WIDTH-1:0];
            ovf_q[c] <= ovf_sel | carry;
          end
        end
      end
    end
  end

  // Completion can only occur when ready_o is high, so a held result is never overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StEmpty;
      res_q     <= '0;
      ch_q      <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (done) begin
            state_q   <= StFull;
            res_q     <= sum_n;
            ch_q      <= ch_i;
            ovf_out_q <= ovf_sel | carry;
          end
        end
        StFull: begin
          if (done) begin
            res_q     <= sum_n;
            ch_q      <= ch_i;
            ovf_out_q <= ovf_sel | carry;
          end else if (ready_i) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_acc_core.sv
// Directed bench for multi_acc_core: a per-channel arithmetic model checked every cycle,
// plus literal expectations on each delivered result.
module tb_multi_acc_core;

  localparam int NC = 4;
  localparam int CW = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   number_i = '0;
  logic [1:0]   ch_i = '0;
  logic         valid_i = 1'b0;
  logic         run_i = 1'b1;
  logic [CW-1:0] len_i = 10'd1;
  logic         sat_en_i = 1'b1;
  logic         ready_i = 1'b1;
  logic         ready_o;
  logic         valid_o;
  logic [1:0]   ch_o;
  logic [15:0]  result_o;
  logic         ovf_o;

  int checks = 0;
  int failures = 0;

  // Wider length field so a single channel can be driven past 2^16.
  multi_acc_core #(
    .IN_DATA_WIDTH(8),
    .DWIDTH(16),
    .NUM_CH(NC),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .number_i(number_i),
    .ch_i(ch_i),
    .valid_i(valid_i),
    .run_i(run_i),
    .len_i(len_i),
    .sat_en_i(sat_en_i),
    .ready_i(ready_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .ch_o(ch_o),
    .result_o(result_o),
    .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Behavioural model
  longint m_acc [NC];
  int     m_cnt [NC];
  bit     m_ovf [NC];
  bit     e_valid;
  longint e_res;
  int     e_ch;
  bit     e_ovf;
  bit     m_rdy, m_take, m_carry;
  longint m_sum;
  int     m_len;
  logic [18:0] got [$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NC; c++) begin
        m_acc[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0;
      end
      e_valid = 0; e_res = 0; e_ch = 0; e_ovf = 0;
    end else begin
      m_rdy  = !e_valid || ready_i;
      m_take = valid_i && run_i && m_rdy && (int'(ch_i) < NC);
      if (e_valid && ready_i) e_valid = 0;
      if (!run_i) begin
        for (int c = 0; c < NC; c++) begin
          m_acc[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0;
        end
      end else if (m_take) begin
        m_sum   = m_acc[ch_i] + longint'(number_i);
        m_carry = m_sum >= 65536;
        if (m_carry) m_sum = sat_en_i ? 65535 : m_sum - 65536;
        m_len = (len_i == 0) ? 1 : int'(len_i);
        if (m_cnt[ch_i] + 1 >= m_len) begin
          e_valid = 1; e_res = m_sum; e_ch = int'(ch_i); e_ovf = m_ovf[ch_i] | m_carry;
          m_acc[ch_i] = 0; m_cnt[ch_i] = 0; m_ovf[ch_i] = 0;
        end else begin
          m_acc[ch_i] = m_sum; m_cnt[ch_i] = m_cnt[ch_i] + 1;
          m_ovf[ch_i] = m_ovf[ch_i] | m_carry;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("valid_o", 64'(valid_o), 64'(e_valid));
      chk("ready_o", 64'(ready_o), 64'(!e_valid || ready_i));
      if (e_valid) begin
        chk("result_o", 64'(result_o), 64'(e_res));
        chk("ch_o", 64'(ch_o), 64'(e_ch));
        chk("ovf_o", 64'(ovf_o), 64'(e_ovf));
      end
      if (valid_o && ready_i) got.push_back({ovf_o, ch_o, result_o});
    end
  end

  task automatic pop_chk(input string name, input int ch, input int res, input bit ovf);
    logic [18:0] r;
    logic [18:0] exp;
    exp = {ovf, 2'(ch), 16'(res)};
    if (got.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got no result expected ch=%0d res=%0h ovf=%0d", name, ch, res, ovf);
    end else begin
      r = got.pop_front();
      chk(name, 64'(r), 64'(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int c, input int n);
    ch_i = 2'(c);
    number_i = 8'(n);
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  initial begin
    #12;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    #8 reset_n = 1'b1;
    step();

    // Long run on ch0: 2..71
    len_i = 10'd70;
    for (int n = 2; n <= 71; n++) send(0, n);
    idle(3);
    pop_chk("len70_sum", 0, 2555, 0);

    // Interleaved channels
    len_i = 10'd2;
    send(0, 10); send(1, 20); send(0, 30); send(1, 40);
    idle(3);
    pop_chk("inter_ch0", 0, 40, 0);
    pop_chk("inter_ch1", 1, 60, 0);

    // Preload 0xFF80, then lower len: saturating and wrapping
    for (int s = 1; s >= 0; s--) begin
      sat_en_i = s[0];
      len_i = 10'd300;
      for (int i = 0; i < 256; i++) send(0, 255);
      send(0, 128);
      len_i = 10'd3;
      for (int i = 0; i < 3; i++) send(0, 255);
      run_i = 1'b0;
      step();
      run_i = 1'b1;
      idle(2);
      if (s == 1) pop_chk("sat_result", 0, 16'hFFFF, 1);
      else        pop_chk("wrap_result", 0, 16'h007F, 1);
    end
    sat_en_i = 1'b1;

    // len 0 behaves as 1
    len_i = 10'd0;
    send(3, 9);
    idle(2);
    pop_chk("len0", 3, 9, 0);

    // Backpressure
    ready_i = 1'b0;
    len_i = 10'd2;
    send(2, 5); send(2, 6);
    send(2, 7); send(2, 8);
    chk("bp_ready_o", 64'(ready_o), 64'd0);
    chk("bp_result", 64'(result_o), 64'd11);
    idle(2);
    ready_i = 1'b1;
    step();
    send(2, 7); send(2, 8);
    idle(2);
    pop_chk("bp_first", 2, 11, 0);
    pop_chk("bp_resume", 2, 15, 0);

    // Abort mid-run
    len_i = 10'd10;
    for (int n = 1; n <= 5; n++) send(0, n);
    run_i = 1'b0;
    step();
    run_i = 1'b1;
    chk("abort_no_out", 64'(got.size()), 64'd0);
    for (int n = 1; n <= 10; n++) send(0, n);
    idle(2);
    pop_chk("abort_sum", 0, 55, 0);

    // Async reset mid-accumulation and mid-FULL
    send(1, 3); send(1, 4); send(1, 5);
    ready_i = 1'b0;
    len_i = 10'd1;
    send(3, 8'h55);
    chk("held_valid", 64'(valid_o), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_result", 64'(result_o), 64'd0);
    chk("arst_ch", 64'(ch_o), 64'd0);
    chk("arst_ovf", 64'(ovf_o), 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    ready_i = 1'b1;
    step();
    len_i = 10'd2;
    send(1, 4); send(1, 5);
    idle(2);
    pop_chk("post_rst", 1, 9, 0);
    chk("no_extra", 64'(got.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_acc_core.md
MULTI_ACC_CORE -- requirements
Module: multi_acc_core

Interface
REQ-001 Parameter IN_DATA_WIDTH, default 8, SHALL set the unsigned input sample width.
REQ-002 Parameter DWIDTH, default 16, SHALL set the accumulator and result width; DWIDTH SHALL be >= IN_DATA_WIDTH.
REQ-003 Parameter NUM_CH, default 4, SHALL set the number of independent channels (>= 2).
REQ-004 Parameter CNT_WIDTH, default 8, SHALL set the width of the accumulation-length field.
REQ-005 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port number_i, input, IN_DATA_WIDTH: unsigned sample.
REQ-008 Port ch_i, input, CH_W = max(1, clog2(NUM_CH)): target channel of the sample.
REQ-009 Port valid_i, input, 1: sample present.
REQ-010 Port run_i, input, 1: 1 = accumulate; 0 = abort/clear.
REQ-011 Port len_i, input, CNT_WIDTH: samples per accumulation; 0 SHALL be treated as 1.
REQ-012 Port sat_en_i, input, 1: 1 = saturating add; 0 = wrap-around add.
REQ-013 Port ready_i, input, 1: downstream accepts the result.
REQ-014 Port ready_o, output, 1: block accepts a sample this cycle.
REQ-015 Port valid_o, output, 1: result register holds a result.
REQ-016 Port ch_o, output, CH_W: channel of the held result.
REQ-017 Port result_o, output, DWIDTH: completed sum.
REQ-018 Port ovf_o, output, 1: one or more additions in this result overflowed DWIDTH.

Function
REQ-019 A sample SHALL be accepted iff valid_i && run_i && ready_o && ch_i < NUM_CH; other samples, including ch_i >= NUM_CH, SHALL be dropped with no state change.
REQ-020 Each channel SHALL hold acc (DWIDTH), cnt (CNT_WIDTH) and a sticky ovf bit.
REQ-021 On acceptance, sum = acc[ch_i] + zero-extended number_i, computed at DWIDTH+1 bits; carry-out SHALL set ovf[ch_i].
REQ-022 On carry-out, sat_en_i=1 SHALL yield 2^DWIDTH-1; sat_en_i=0 SHALL yield sum mod 2^DWIDTH.
REQ-023 Completion occurs when the accepted sample is the channel's len_i-th sample, i.e. cnt+1 >= max(len_i,1); len_i SHALL be compared on every sample, so lowering len_i mid-run SHALL complete the channel on its next sample.
REQ-024 On completion, the new sum, ch_i and ovf (including the current carry) SHALL load the result register, and acc, cnt and ovf of that channel SHALL clear; valid_o SHALL rise one cycle after the accepting edge.
REQ-025 Otherwise acc, cnt and ovf of that channel SHALL update, with no output.
REQ-026 Output stage states SHALL be EMPTY (valid_o=0) and FULL (valid_o=1); EMPTY->FULL on completion; FULL->EMPTY on ready_i with no new completion; FULL->FULL with new data on ready_i plus a completion in the same cycle.
REQ-027 ready_o SHALL be combinationally !valid_o || ready_i, so a result is never overwritten while unconsumed.
REQ-028 result_o, ch_o and ovf_o SHALL stay stable while valid_o=1 && ready_i=0.
REQ-029 run_i=0 SHALL synchronously clear acc, cnt and ovf of all channels while leaving the output stage untouched; a held result SHALL still drain.
REQ-030 Channels SHALL be fully independent; interleaved samples SHALL not affect other channels.

Reset
REQ-031 reset_n=0 SHALL immediately force valid_o=0, result_o=0, ch_o=0, ovf_o=0 and clear every channel's acc, cnt and ovf, including mid-accumulation.
REQ-032 After reset_n rises, the first accepted sample SHALL be treated as sample 1 of its channel.

Verification
REQ-033 Defaults, len_i=70, ready_i=1, ch 0, samples 2..71 -> one valid_o pulse, result_o=2555, ovf_o=0, ch_o=0.
REQ-034 len_i=2, samples alternating ch0=10, ch1=20, ch0=30, ch1=40 -> results (ch0,40) then (ch1,60), in that order.
REQ-035 DWIDTH=16, len_i=3, samples 0xFF x3 onto acc preloaded by prior run to 0xFF80 (len_i raised) -> sat_en_i=1 gives 0xFFFF with ovf_o=1; sat_en_i=0 gives the wrapped value with ovf_o=1.
REQ-036 ready_i=0 with a result held -> ready_o=0, further samples ignored, outputs stable; ready_i=1 -> result drains and accumulation resumes.
REQ-037 run_i=0 pulsed after 5 of 10 samples on ch0 -> no output; next 10 samples produce only their own sum.
REQ-038 reset_n asserted asynchronously mid-accumulation and mid-FULL -> valid_o=0 and result_o=0 before the next clock edge; fresh accumulation afterwards is correct.
